mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store sequencer between execute and MemoryFetch (1-port sync BRAM, word-addressed).
//  Accepts one op per valid/ready handshake and drives mem_read/mem_write/address/input_data.
//  Waits out the BRAM read latency and captures read data.
//  Emits one writeback beat (rd, data, reg_write) to the register file.
// PARAMETERS
//  ADDR_W  10  word-address bits decoded by the memory; higher address bits must be zero
//  DATA_W  32  data width
//  REG_W   5   register index width
//  RD_LAT  1   BRAM read latency in cycles (legal 1..3)
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       asynchronous, active-high reset
//  req_valid       in   1       execute presents an op
//  req_ready       out  1       block can accept (high only in IDLE)
//  req_load        in   1       op is a load
//  req_store       in   1       op is a store
//  req_addr        in   32      effective word address
//  req_wdata       in   DATA_W  store data
//  req_alu_result  in   DATA_W  result for non-memory ops
//  req_rd          in   REG_W   destination register
//  req_reg_write   in   1       op writes rd
//  mem_read        out  1       to MemoryFetch.mem_read
//  mem_write       out  1       to MemoryFetch.mem_write
//  mem_address     out  32      to MemoryFetch.address
//  mem_wdata       out  DATA_W  to MemoryFetch.input_data
//  mem_rdata       in   DATA_W  from MemoryFetch.output_data
//  wb_valid        out  1       one-cycle writeback pulse
//  wb_rd           out  REG_W   writeback register index
//  wb_data         out  DATA_W  writeback data
//  wb_reg_write    out  1       register-file write enable (qualified by wb_valid)
//  addr_err        out  1       pulses with wb_valid when req_addr[31:ADDR_W] != 0
// BEHAVIOUR
//  - Reset (async): state=IDLE, wait counter=0, all outputs 0.
//    An in-flight op is dropped and no wb_valid is issued. req_ready=1 on the first cycle after release.
//  - Accept: req_valid & req_ready at a rising edge (cycle 0). All req_* fields are registered.
//  - Priority: if req_load and req_store are both set, the op is a load and the store is ignored.
//  - Non-memory op (neither load nor store): stays in IDLE.
//    wb_valid=1 in cycle 1 with data=req_alu_result, no memory access; back-to-back ops at full rate.
//  - Store, cycle 1 (ACCESS): mem_write=1 for exactly one cycle, mem_address=req_addr, mem_wdata=req_wdata.
//    Cycle 2: wb_valid=1, wb_reg_write=0, state=IDLE.
//  - Load, cycle 1 (ACCESS): mem_read=1, address driven.
//    Then WAIT for RD_LAT cycles with mem_read and mem_address held.
//    mem_rdata is sampled at the end of cycle 1+RD_LAT.
//    Cycle 2+RD_LAT: wb_valid=1, wb_data=sampled data, state=IDLE.
//    Load latency is RD_LAT+2 cycles from accept (3 cycles when RD_LAT=1).
//  - wb_reg_write = registered req_reg_write for loads and ALU ops. It is 0 for stores.
//  - The transition to IDLE coincides with the wb_valid cycle, so req_ready=1 then.
//    A new op may be accepted in the same cycle that wb_valid is high.
//  - mem_read and mem_write are 0 outside ACCESS/WAIT. They are never both 1.
//  - mem_address and mem_wdata hold their last values when memory is idle.
//  - Out-of-range address (req_addr[31:ADDR_W] != 0):
//    no mem_read/mem_write strobe and no wrap-around; timing is unchanged.
//    A load returns wb_data=0; a store is suppressed; addr_err=1 in the wb_valid cycle.
//  - wb_rd, wb_data and wb_reg_write hold until the next wb_valid.
//  - FSM: IDLE -> ACCESS (load/store accepted); ACCESS -> IDLE (store) or WAIT (load);
//    WAIT -> IDLE once RD_LAT cycles have elapsed. Any state -> IDLE on rst.
// TESTING
//  1 ALU op rd=3, alu=0x1234 -> wb_valid in cycle 1, wb_rd=3, wb_data=0x1234, wb_reg_write=1, mem strobes 0.
//  2 store addr=0x10, wdata=0xDEADBEEF, then load rd=5 addr=0x10 ->
//    single mem_write pulse; load wb_valid 3 cycles after accept with wb_data=0xDEADBEEF.
//  3 Back-to-back loads (RD_LAT=1): second op accepted in the first op's wb_valid cycle ->
//    wb_valid pulses 3 cycles apart, data in order.
//  4 Load addr=0x400 (ADDR_W=10) -> no mem_read, wb_data=0, addr_err=1 with wb_valid.
//    Store to 0x400 -> no mem_write, addr_err=1.
//  5 rst asserted during a load's WAIT -> all outputs 0 immediately.
//    No wb_valid for that load; req_ready=1 after release.
//  6 req_load=req_store=1, RD_LAT=3 -> treated as a load: mem_write never 1, wb_valid 5 cycles after accept.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the execute stage and a
// single-port, word-addressed synchronous BRAM. It accepts one op per
// valid/ready handshake, drives the memory strobes, and waits out the read
// latency. Each op produces exactly one writeback beat for the register file.
module mem_access_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_alu_result,
    input  logic [REG_W-1:0]  req_rd,
    input  logic              req_reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_write,
    output logic              addr_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    // Final count of the WAIT phase; WAIT lasts exactly RD_LAT cycles.
    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

    logic [1:0]       state_r;
    logic [1:0]       wait_cnt_r;
    logic             op_load_r;
    logic             op_oor_r;
    logic [REG_W-1:0] op_rd_r;
    logic             op_rw_r;

    logic accept_s;
    logic is_load_s;
    logic is_store_s;
    logic is_mem_s;
    logic oor_s;

    // Decode the presented op; a load wins when both load and store are set.
    always_comb begin
        accept_s   = req_valid & req_ready;
        is_load_s  = req_load;
        is_store_s = req_store & ~req_load;
        is_mem_s   = is_load_s | is_store_s;
        oor_s      = |req_addr[31:ADDR_W];
    end

    // Sequencer state, memory strobes and writeback beat, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 2'd0;
            op_load_r    <= 1'b0;
            op_oor_r     <= 1'b0;
            op_rd_r      <= {REG_W{1'b0}};
            op_rw_r      <= 1'b0;
            req_ready    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= 32'd0;
            mem_wdata    <= {DATA_W{1'b0}};
            wb_valid     <= 1'b0;
            wb_rd        <= {REG_W{1'b0}};
            wb_data      <= {DATA_W{1'b0}};
            wb_reg_write <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            // Writeback and error flags are single-cycle pulses.
            wb_valid <= 1'b0;
            addr_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept_s) begin
                        if (is_mem_s) begin
                            // Capture the op; an out-of-range address never strobes memory.
                            state_r     <= ST_ACCESS;
                            req_ready   <= 1'b0;
                            op_load_r   <= is_load_s;
                            op_oor_r    <= oor_s;
                            op_rd_r     <= req_rd;
                            op_rw_r     <= is_load_s & req_reg_write;
                            mem_address <= req_addr;
                            mem_read    <= is_load_s & ~oor_s;
                            mem_write   <= is_store_s & ~oor_s;
                            if (is_store_s) begin
                                mem_wdata <= req_wdata;
                            end else begin
                                mem_wdata <= mem_wdata;
                            end
                        end else begin
                            // ALU result goes straight to writeback; stay in IDLE.
                            wb_valid     <= 1'b1;
                            wb_rd        <= req_rd;
                            wb_data      <= req_alu_result;
                            wb_reg_write <= req_reg_write;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_write <= 1'b0;
                    if (op_load_r) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= 2'd0;
                    end else begin
                        // Store completes: writeback beat carries no register write.
                        state_r      <= ST_IDLE;
                        req_ready    <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_rd        <= op_rd_r;
                        wb_reg_write <= 1'b0;
                        addr_err     <= op_oor_r;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == LAST_WAIT) begin
                        // Read data is valid now; capture it and retire the load.
                        state_r      <= ST_IDLE;
                        req_ready    <= 1'b1;
                        mem_read     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= op_rd_r;
                        wb_reg_write <= op_rw_r;
                        addr_err     <= op_oor_r;
                        if (op_oor_r) begin
                            wb_data <= {DATA_W{1'b0}};
                        end else begin
                            wb_data <= mem_rdata;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
